// File: rtl/writeback_stage.sv
// writeback_stage
// Memory/writeback stage of the 3-stage RV32I pipeline.
// The MW pipeline register captures the instruction leaving execute.
// Loads and stores then make a data-memory access through a request/ack
// handshake, which stalls execute while the access is outstanding.
// The stage selects the writeback value, drives the register-file write
// port, and flags misaligned loads and stores to the trap unit.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   ex_*          instruction presented by execute; ex_ready back-pressures it
//   flush         trap/interrupt kill from the CSR unit
//   dmem_*        data-memory request channel (word-aligned address, lane mask)
//   reg_wrMW, waddr_MW, wdata   register-file write port
//   misalign, misalign_addr     one-cycle misaligned-access report
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wr,
    input  logic [1:0]  ex_wb_sel,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_csr_rdata,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        reg_wrMW,
    output logic [4:0]  waddr_MW,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] misalign_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        MEM    = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        kill_reg, kill_next;

    logic [31:0] pc_reg, result_reg, rs2_reg, csr_rdata_reg, load_data_reg;
    logic [4:0]  rd_reg;
    logic        reg_wr_reg, mem_rd_reg, mem_wr_reg, misaligned_reg;
    logic [1:0]  wb_sel_reg;
    logic [2:0]  funct3_reg;

    logic        capture, ex_is_mem, ex_misaligned;
    logic [31:0] load_data_next;
    logic [7:0]  rdata_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign ex_ready  = (state_reg != MEM);
    assign capture   = ex_valid && ex_ready && !flush;
    assign ex_is_mem = ex_mem_rd || ex_mem_wr;

    // Only H/HU and W accesses have alignment constraints; bytes never fault.
    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   ex_misaligned = ex_alu_result[0];
            2'b10:   ex_misaligned = (ex_alu_result[1:0] != 2'b00);
            default: ex_misaligned = 1'b0;
        endcase
    end

    // Split the returned word into byte lanes for the load extraction mux.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rdata_lane
            assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rdata_byte[result_reg[1:0]];
    assign sel_half = result_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data_next = dmem_rdata;
        case (funct3_reg)
            3'b000:  load_data_next = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data_next = {24'h000000, sel_byte};
            3'b001:  load_data_next = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data_next = {16'h0000, sel_half};
            default: load_data_next = dmem_rdata;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_next    = state_reg;
        kill_next     = kill_reg;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = 32'h0;
        dmem_wdata    = 32'h0;
        dmem_wmask    = 4'b0000;
        reg_wrMW      = 1'b0;
        waddr_MW      = rd_reg;
        wdata         = result_reg;
        misalign      = 1'b0;
        misalign_addr = 32'h0;

        case (state_reg)
            IDLE, COMMIT: begin
                // Kill only ever shadows the instruction that was in MEM.
                kill_next = 1'b0;
                if (capture)
                    state_next = (ex_is_mem && !ex_misaligned) ? MEM : COMMIT;
                else
                    state_next = IDLE;
            end
            MEM: begin
                // A flush cannot abort an access already on the bus; the
                // result is discarded instead.
                if (flush)
                    kill_next = 1'b1;
                if (dmem_ack)
                    state_next = COMMIT;
            end
            default: state_next = IDLE;
        endcase

        if (state_reg == MEM) begin
            dmem_req  = 1'b1;
            dmem_we   = mem_wr_reg;
            dmem_addr = {result_reg[31:2], 2'b00};
            case (funct3_reg[1:0])
                2'b00: begin
                    dmem_wdata = {4{rs2_reg[7:0]}};
                    dmem_wmask = 4'b0001 << result_reg[1:0];
                end
                2'b01: begin
                    dmem_wdata = {2{rs2_reg[15:0]}};
                    dmem_wmask = result_reg[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem_wdata = rs2_reg;
                    dmem_wmask = 4'b1111;
                end
            endcase
        end

        if (state_reg == COMMIT) begin
            reg_wrMW = reg_wr_reg && (rd_reg != 5'd0) && !mem_wr_reg
                       && !misaligned_reg && !kill_reg && !flush;
            if (misaligned_reg) begin
                misalign      = 1'b1;
                misalign_addr = result_reg;
            end
        end

        case (wb_sel_reg)
            2'b00:   wdata = result_reg;
            2'b01:   wdata = load_data_reg;
            2'b10:   wdata = pc_reg + 32'd4;
            default: wdata = csr_rdata_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            kill_reg       <= 1'b0;
            pc_reg         <= 32'h0;
            result_reg     <= 32'h0;
            rs2_reg        <= 32'h0;
            csr_rdata_reg  <= 32'h0;
            load_data_reg  <= 32'h0;
            rd_reg         <= 5'd0;
            reg_wr_reg     <= 1'b0;
            wb_sel_reg     <= 2'b00;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            funct3_reg     <= 3'b000;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            kill_reg  <= kill_next;
            if (capture) begin
                pc_reg         <= ex_pc;
                result_reg     <= ex_alu_result;
                rs2_reg        <= ex_rs2_data;
                csr_rdata_reg  <= ex_csr_rdata;
                rd_reg         <= ex_rd;
                reg_wr_reg     <= ex_reg_wr;
                wb_sel_reg     <= ex_wb_sel;
                mem_rd_reg     <= ex_mem_rd;
                mem_wr_reg     <= ex_mem_wr;
                funct3_reg     <= ex_funct3;
                misaligned_reg <= ex_is_mem && ex_misaligned;
            end
            if (state_reg == MEM && dmem_ack)
                load_data_reg <= load_data_next;
        end
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Memory/writeback stage of the 3-stage RV32I pipeline. Captures the instruction leaving execute into the MW pipeline register, performs the data-memory access (with byte-lane alignment, sign/zero extension and a request/ack handshake that may stall execute), selects the writeback value and drives the register file's write port. It also reports misaligned load/store accesses to the CSR/trap unit.

## Interface
Parameters:
- none (RV32I widths fixed: XLEN=32, 5-bit register addresses)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ex_valid  in  1  execute presents a valid instruction
- ex_ready  out  1  stage can accept the instruction this cycle
- ex_pc  in  32  PC of the presented instruction
- ex_alu_result  in  32  ALU result; effective address for loads/stores
- ex_rs2_data  in  32  store data
- ex_rd  in  5  destination register
- ex_reg_wr  in  1  instruction writes rd
- ex_wb_sel  in  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 CSR read data
- ex_mem_rd  in  1  load
- ex_mem_wr  in  1  store
- ex_funct3  in  3  load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_csr_rdata  in  32  CSR read value
- flush  in  1  trap/interrupt kill from the CSR unit
- dmem_req  out  1  memory request, held until acknowledged
- dmem_we  out  1  request is a store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data replicated into lanes
- dmem_wmask  out  4  byte-lane write enables
- dmem_ack  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  load word, valid in the cycle dmem_ack=1
- reg_wrMW  out  1  register-file write enable
- waddr_MW  out  5  register-file write address
- wdata  out  32  register-file write data
- misalign  out  1  one-cycle pulse: misaligned access detected
- misalign_addr  out  32  offending address, valid with misalign

## Operation
- States: IDLE (empty), COMMIT (result ready), MEM (access outstanding).
- ex_ready = (state != MEM). Capture when ex_valid && ex_ready && !flush; latch pc, result, rs2, rd, reg_wr, wb_sel, mem_rd, mem_wr, funct3, csr_rdata.
- Capture of a non-memory op -> COMMIT. Capture of an aligned load/store -> MEM. Capture of a misaligned load/store -> COMMIT, with misalign=1 and misalign_addr=address in that COMMIT cycle, no memory request, and the write suppressed.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. B/BU are never misaligned.
- COMMIT with no new capture -> IDLE; with a capture -> COMMIT or MEM as above. IDLE with no capture stays IDLE.
- MEM: dmem_req=1 and stable until dmem_ack. On ack: latch the extracted load data, then -> COMMIT.
- Load extraction from dmem_rdata by addr[1:0]:
  - B/BU: select byte addr[1:0]; sign-extend for B, zero-extend for BU.
  - H/HU: select half addr[1]; sign-extend for H, zero-extend for HU.
  - W: whole word.
- Store lanes:
  - B: wdata={4{rs2[7:0]}}, mask=1<<addr[1:0].
  - H: wdata={2{rs2[15:0]}}, mask=addr[1]?1100:0011.
  - W: mask=1111.
- reg_wrMW = (state==COMMIT) && reg_wr && rd!=0 && !misaligned && !killed && !flush. Stores never write.
- wdata mux by wb_sel: ALU result, latched load data, pc+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), csr_rdata.
- waddr_MW = latched rd.
- flush:
  - IDLE/COMMIT: blocks the capture and suppresses the write of the held instruction.
  - MEM: sets a kill flag; the access still completes (stores still write memory), and the load result is discarded at COMMIT. The kill flag clears on leaving COMMIT.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, kill=0, all pipeline registers 0. Outputs: ex_ready=1, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wmask=0, reg_wrMW=0, waddr_MW=0, wdata=0, misalign=0, misalign_addr=0.
- Reset mid-MEM drops dmem_req immediately; the outstanding access is abandoned.
- ALU/PC+4/CSR ops: captured at edge N, write enable asserted in cycle N+1. The register file writes on the following negedge, so the value is readable in the second half of cycle N+1.
- Memory ops: request asserted in cycle N+1. With ack in cycle N+k, COMMIT occurs in cycle N+k+1. ex_ready=0 for cycles N+1..N+k.
- Zero-wait memory (ack in the first request cycle): load-to-write latency is 2 cycles; throughput is 1 memory op per 2 cycles.
- Back-to-back non-memory ops sustain 1 per cycle.
- dmem_addr, dmem_we, dmem_wdata and dmem_wmask are stable while dmem_req=1.

## Test plan
- ADDI result: ex_rd=5, ex_wb_sel=00, ex_alu_result=0x0000002A -> next cycle reg_wrMW=1, waddr_MW=5, wdata=0x2A. Repeat with rd=0 -> reg_wrMW=0.
- LB at 0x1003, dmem_rdata=0x80FF1234, ack after 3 wait cycles -> dmem_addr=0x1000, ex_ready low 4 cycles, wdata=0xFFFFFF80. LBU -> 0x00000080. LH at 0x1002 -> 0xFFFF80FF.
- SH at 0x2002, rs2=0xDEADBEEF -> dmem_we=1, dmem_wdata=0xBEEFBEEF, dmem_wmask=1100, reg_wrMW=0.
- LW at 0x3001 -> misalign=1 for one cycle, misalign_addr=0x3001, dmem_req never asserts, reg_wrMW=0.
- JAL at ex_pc=0xFFFFFFFC, wb_sel=10 -> wdata=0x00000000. flush during MEM of a load -> access completes, reg_wrMW=0.
- Assert rst=0 mid-MEM -> dmem_req=0 immediately. After release -> IDLE, ex_ready=1, all outputs 0.
